// File: rtl/tohost_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tohost_monitor
// Purpose  : Passive watcher on a core's data-memory write port. It detects
//            the RISC-V style "tohost" exit write and reports the test
//            outcome. An optional watchdog (TOHOST_TIMEOUT_EN) ends the test
//            if no exit write arrives in time.
// Macro    : TOHOST_TIMEOUT_EN - define it to compile the watchdog in.
//            Leave it undefined and timeout is tied low, so the monitor can
//            stay in RUN for ever.
// Ports    : clk          - the single clock; all state changes on its rising edge
//            rst_n        - asynchronous, active-low reset
//            mem_we       - core data-memory write enable
//            mem_addr     - core data-memory byte address
//            mem_wdata    - core data-memory write data
//            done         - sticky; the test has ended (exit or timeout)
//            pass         - sticky; exit code 0 was received
//            fail_code    - exit code (mem_wdata[31:1]) of a failing exit
//            timeout      - sticky; the watchdog expired before any exit write
//            cycle_count  - cycles spent in RUN; saturates at all-ones
// Revision : 1.0 - initial release
// ============================================================================
module tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h8000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        timeout,
    output logic [31:0] cycle_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    state_t state;

    // An exit write needs an exact address match and bit 0 set. With bit 0
    // clear, a write to tohost is a syscall request and is not an exit.
    logic exit_write;
    logic exit_clean;

    assign exit_write = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
    assign exit_clean = (mem_wdata[31:1] == 31'd0);

`ifdef TOHOST_TIMEOUT_EN
    // Last RUN cycle the watchdog allows. Leaving RUN on this cycle freezes
    // cycle_count at exactly TIMEOUT_CYCLES.
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= 31'd0;
            cycle_count <= 32'd0;
`ifdef TOHOST_TIMEOUT_EN
            timeout     <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    // The exit-write cycle itself is counted.
                    if (cycle_count != 32'hFFFF_FFFF) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                    if (exit_write) begin
                        done <= 1'b1;
                        if (exit_clean) begin
                            state <= PASS;
                            pass  <= 1'b1;
                        end else begin
                            state     <= FAIL;
                            fail_code <= mem_wdata[31:1];
                        end
                    end
`ifdef TOHOST_TIMEOUT_EN
                    // An exit write on the same cycle takes priority over
                    // the watchdog.
                    else if (cycle_count == TIMEOUT_LAST) begin
                        state   <= TIMEOUT;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
`endif
                end
                // PASS, FAIL and TIMEOUT are absorbing. Only reset leaves them.
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tohost_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_tohost_monitor
// Purpose  : Self-checking bench for tohost_monitor. A driver applies
//            directed and random write traffic. A test-outcome model turns
//            each cycle into an expected output set and queues it, and a
//            monitor compares each queued entry once the clock edge it
//            refers to has passed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tohost_monitor;

    localparam logic [31:0] TADDR = 32'h8000_1000;
`ifdef TOHOST_TIMEOUT_EN
    localparam int unsigned TMO    = 16;
    localparam bit          TMO_EN = 1'b1;
`else
    localparam int unsigned TMO    = 5000;
    localparam bit          TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        done, pass, timeout;
    logic [30:0] fail_code;
    logic [31:0] cycle_count;

    tohost_monitor #(
        .TOHOST_ADDR    (TADDR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        done;
        logic        pass;
        logic        tmo;
        logic [30:0] code;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   edges = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) edges <= edges + 1;

    // Test-outcome model: outcome 0=running 1=passed 2=failed 3=timed out.
    int          outcome = 0;
    logic [31:0] run_cycles = 32'd0;
    logic [30:0] code = 31'd0;

    task automatic check(input string name, input exp_t e);
        total++;
        if (done !== e.done || pass !== e.pass || timeout !== e.tmo ||
            fail_code !== e.code || cycle_count !== e.cnt) begin
            bad++;
            $display("FAIL %s: got done=%b pass=%b timeout=%b code=%0d cnt=%0d, want done=%b pass=%b timeout=%b code=%0d cnt=%0d",
                     name, done, pass, timeout, fail_code, cycle_count,
                     e.done, e.pass, e.tmo, e.code, e.cnt);
        end
    endtask

    function automatic exp_t expected(input int id);
        exp_t e;
        e.id   = id;
        e.done = (outcome != 0);
        e.pass = (outcome == 1);
        e.tmo  = (outcome == 3);
        e.code = code;
        e.cnt  = run_cycles;
        return e;
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input logic rn, input logic we,
                              input logic [31:0] a, input logic [31:0] d);
        if (!rn) begin
            outcome    = 0;
            run_cycles = 32'd0;
            code       = 31'd0;
        end else if (outcome == 0) begin
            if (run_cycles != 32'hFFFF_FFFF) run_cycles = run_cycles + 32'd1;
            if (we && a == TADDR && d[0]) begin
                if (d[31:1] == 31'd0) begin
                    outcome = 1;
                end else begin
                    outcome = 2;
                    code    = d[31:1];
                end
            end else if (TMO_EN && run_cycles == TMO) begin
                outcome = 3;
            end
        end
    endtask

    // One clock cycle. Inputs change just after the falling edge, and the
    // expectation is queued for the next rising edge.
    task automatic cyc(input logic rn, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        #1;
        rst_n     = rn;
        mem_we    = we;
        mem_addr  = a;
        mem_wdata = d;
        model_step(rn, we, a, d);
        q.push_back(expected(edges + 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Assert reset between clock edges and check that the outputs clear
    // without waiting for a clock edge.
    task automatic mid_reset();
        exp_t z;
        @(negedge clk);
        #1;
        rst_n  = 1'b0;
        mem_we = 1'b0;
        model_step(1'b0, 1'b0, 32'd0, 32'd0);
        z = expected(edges + 1);
        q.push_back(z);
        #1;
        check("async_reset", z);
    endtask

    // Monitor: compare every queued expectation whose edge has passed.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].id <= edges) begin
            exp_t e;
            e = q.pop_front();
            check($sformatf("edge%0d", e.id), e);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, 10 idle cycles, then a passing exit.
        do_reset();
        idle(10);
        cyc(1'b1, 1'b1, TADDR, 32'h1);
        idle(3);
        // A failing exit with code 3, then a later passing write is ignored.
        do_reset();
        idle(2);
        cyc(1'b1, 1'b1, TADDR, 32'h7);
        idle(2);
        cyc(1'b1, 1'b1, TADDR, 32'h1);
        idle(2);
        // A syscall write, misaligned writes and a wrong address all leave
        // the test running.
        do_reset();
        cyc(1'b1, 1'b1, TADDR, 32'h2);
        cyc(1'b1, 1'b1, 32'h8000_1004, 32'h1);
        cyc(1'b1, 1'b1, TADDR + 32'd1, 32'h1);
        cyc(1'b1, 1'b1, TADDR + 32'd2, 32'h1);
        cyc(1'b1, 1'b1, TADDR + 32'd3, 32'h1);
        cyc(1'b1, 1'b0, TADDR, 32'h1);
        idle(3);
        // Reset mid-run, then an exit 3 cycles after release.
        idle(5);
        mid_reset();
        cyc(1'b0, 1'b0, 32'd0, 32'd0);
        idle(3);
        cyc(1'b1, 1'b1, TADDR, 32'h1);
        idle(2);
        // Reset in a terminal state, plus an exit write on a reset edge.
        mid_reset();
        cyc(1'b0, 1'b1, TADDR, 32'h1);
        idle(4);
        // Watchdog behaviour.
        do_reset();
        if (TMO_EN) begin
            idle(20);
            do_reset();
            idle(TMO - 1);
            cyc(1'b1, 1'b1, TADDR, 32'h1);
            idle(3);
        end else begin
            idle(6000);
        end
        // Random traffic with occasional resets.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int c = 0; c < 250; c++) begin
                int          k;
                logic [31:0] d;
                k = $urandom_range(0, 99);
                d = $urandom;
                if (k < 2) begin
                    cyc(1'b0, 1'b0, 32'd0, 32'd0);
                end else if (k < 8) begin
                    if ($urandom_range(0, 1) == 0) d = 32'd0;
                    cyc(1'b1, 1'b1, TADDR, d | 32'd1);
                end else if (k < 25) begin
                    cyc(1'b1, 1'b1, TADDR, d & ~32'd1);
                end else if (k < 35) begin
                    cyc(1'b1, 1'b1, TADDR + 32'($urandom_range(1, 7)), d | 32'd1);
                end else if (k < 45) begin
                    cyc(1'b1, 1'b1, $urandom, d | 32'd1);
                end else begin
                    cyc(1'b1, 1'b0, ($urandom_range(0, 1) == 0) ? TADDR : 32'($urandom), d);
                end
            end
        end
        // Drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tohost_monitor.md
TOHOST_MONITOR -- requirements
Module: tohost_monitor

Interface
REQ-001 SHALL have parameter TOHOST_ADDR, default 32'h8000_1000: byte address of the tohost word.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5000: watchdog limit in clock cycles.
REQ-003 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port mem_we  input  1  core data-memory write enable, same cycle as addr/data.
REQ-006 SHALL have port mem_addr  input  32  core data-memory byte address.
REQ-007 SHALL have port mem_wdata  input  32  core data-memory write data.
REQ-008 SHALL have port done  output  1  sticky; test has terminated (exit or timeout).
REQ-009 SHALL have port pass  output  1  sticky; exit code 0 received.
REQ-010 SHALL have port fail_code  output  31  exit code (mem_wdata[31:1]) captured at exit; 0 on pass or timeout.
REQ-011 SHALL have port timeout  output  1  sticky; watchdog expired before any exit write.
REQ-012 SHALL have port cycle_count  output  32  cycles spent in RUN.

Function
REQ-013 SHALL passively monitor the core write port and never drive or stall it.
REQ-014 SHALL implement FSM states RUN, PASS, FAIL, TIMEOUT; RUN is the only non-terminal state.
REQ-015 Exit write: mem_we=1, mem_addr==TOHOST_ADDR exactly, mem_wdata[0]=1; other addresses and misaligned matches SHALL be ignored.
REQ-016 Writes to TOHOST_ADDR with mem_wdata[0]=0 (syscall-style) SHALL be ignored; state stays RUN.
REQ-017 In RUN, an exit write with mem_wdata[31:1]==0 SHALL move to PASS on the next edge; nonzero SHALL move to FAIL with fail_code=mem_wdata[31:1].
REQ-018 Outputs SHALL be registered: done/pass/fail_code/timeout update one cycle after the exit-write cycle.
REQ-019 done SHALL equal (state != RUN); pass=1 only in PASS; timeout=1 only in TIMEOUT.
REQ-020 Terminal states SHALL be absorbing; later writes SHALL not change any output.
REQ-021 cycle_count SHALL increment by 1 each cycle in RUN, freeze on leaving RUN, saturate at 32'hFFFF_FFFF.
REQ-022 The exit-write cycle SHALL be counted; the cycle_count value frozen in PASS/FAIL equals the number of RUN cycles including it.

Reset
REQ-023 rst_n=0 SHALL immediately force state=RUN, done=0, pass=0, timeout=0, fail_code=0, cycle_count=0, independent of clk.
REQ-024 Reset asserted mid-test or in a terminal state SHALL discard all results; counting restarts from 0 on the first edge after release.
REQ-025 A write presented on the edge coinciding with rst_n=0 SHALL be ignored.

Configuration
REQ-026 Macro TOHOST_TIMEOUT_EN SHALL compile the watchdog in or out.
REQ-027 With TOHOST_TIMEOUT_EN defined: in RUN, when cycle_count==TIMEOUT_CYCLES-1 and no exit write that cycle, next edge SHALL enter TIMEOUT; a coincident exit write SHALL win (PASS/FAIL).
REQ-028 Without TOHOST_TIMEOUT_EN: no TIMEOUT state logic; timeout SHALL be tied 0 and RUN persists indefinitely.

Verification
REQ-029 Reset, 10 idle cycles, write 32'h1 to 32'h8000_1000 -> next cycle done=1, pass=1, fail_code=0, cycle_count=11.
REQ-030 Write 32'h7 to TOHOST_ADDR -> done=1, pass=0, fail_code=3; later write 32'h1 -> outputs unchanged.
REQ-031 Write 32'h2 to TOHOST_ADDR, then 32'h1 to 32'h8000_1004 -> done=0 throughout, cycle_count keeps incrementing.
REQ-032 TOHOST_TIMEOUT_EN, TIMEOUT_CYCLES=16, no writes -> done=1, timeout=1 after 16 cycles, cycle_count frozen at 16; exit write on cycle 16 instead -> pass=1, timeout=0.
REQ-033 Run 5 cycles, assert rst_n=0 between edges -> all outputs 0 immediately; release, exit write of 32'h1 after 3 cycles -> pass=1, cycle_count=4.
REQ-034 Without TOHOST_TIMEOUT_EN, 6000 idle cycles -> timeout=0, done=0, cycle_count=6000.
